// File: rtl/dest_reg_scoreboard_if.sv
// Issue / write-back / source-check bundle for dest_reg_scoreboard.
// master: issue and write-back side of the pipeline; slave: the scoreboard.
interface dest_reg_scoreboard_if #(
  parameter int ADDR_W = 5,
  parameter int NREG   = 32,
  parameter int CNT_W  = 2
) ();
  logic                    issue_valid;
  logic [ADDR_W-1:0]       issue_dest;
  logic                    issue_ready;
  logic                    wb_valid;
  logic [ADDR_W-1:0]       wb_dest;
  logic [ADDR_W-1:0]       rs_addr;
  logic [ADDR_W-1:0]       rt_addr;
  logic                    rs_busy;
  logic                    rt_busy;
  logic [NREG-1:0]         busy_vec;
  logic [ADDR_W+CNT_W-1:0] total_pending;
  logic                    wb_underflow;

  modport master (
    output issue_valid, issue_dest, wb_valid, wb_dest, rs_addr, rt_addr,
    input  issue_ready, rs_busy, rt_busy, busy_vec, total_pending, wb_underflow
  );

  modport slave (
    input  issue_valid, issue_dest, wb_valid, wb_dest, rs_addr, rt_addr,
    output issue_ready, rs_busy, rt_busy, busy_vec, total_pending, wb_underflow
  );
endinterface

// File: rtl/dest_reg_scoreboard.sv
// Destination-register scoreboard: one saturating outstanding-write counter
// per architectural register, incremented on accepted issue and decremented
// on write-back. Register 0 is hardwired idle.
// Optional macro SB_WB_BYPASS_EN: hide busy on rs/rt when the write-back
// retiring the last outstanding write to that register happens this cycle.
module dest_reg_scoreboard #(
  parameter int ADDR_W = 5,
  parameter int NREG   = 32,
  parameter int CNT_W  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  dest_reg_scoreboard_if.slave sb
);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam int               TOT_W   = ADDR_W + CNT_W;

  logic [CNT_W-1:0] cnt_reg  [NREG];
  logic [CNT_W-1:0] cnt_next [NREG];
  logic [TOT_W-1:0] total_reg;
  logic [TOT_W-1:0] total_next;
  logic             uf_reg;
  logic             uf_next;
  logic [NREG-1:0]  busy;

  logic same_dest;
  logic issue_ready_w;
  logic issue_acc;
  logic wb_eff;
  logic wb_uf_evt;
  logic wb_dec;

  // A full counter only accepts another issue when a write-back to the same
  // register frees a slot in the same cycle.
  assign same_dest     = sb.wb_valid && (sb.wb_dest == sb.issue_dest);
  assign issue_ready_w = !((cnt_reg[sb.issue_dest] == CNT_MAX) && !same_dest);
  assign issue_acc     = sb.issue_valid && issue_ready_w && (sb.issue_dest != '0);
  assign wb_eff        = sb.wb_valid && (sb.wb_dest != '0);
  // Write-back with nothing outstanding and no same-cycle issue to cover it.
  assign wb_uf_evt     = wb_eff && (cnt_reg[sb.wb_dest] == '0) && !(issue_acc && same_dest);
  assign wb_dec        = wb_eff && !wb_uf_evt;

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_cnt
      if (gi == 0) begin : g_zero
        assign cnt_next[gi] = '0;
        assign busy[gi]     = 1'b0;
      end else begin : g_reg
        logic inc;
        logic dec;
        assign inc = issue_acc && (sb.issue_dest == ADDR_W'(gi));
        assign dec = wb_eff && (sb.wb_dest == ADDR_W'(gi));
        // Net +1/-1/0; decrement clamps at zero, increment is gated by ready.
        assign cnt_next[gi] = (inc && !dec) ? cnt_reg[gi] + 1'b1 :
                              (dec && !inc && (cnt_reg[gi] != '0)) ? cnt_reg[gi] - 1'b1 :
                              cnt_reg[gi];
        assign busy[gi] = (cnt_reg[gi] != '0);
      end
    end
  endgenerate

  // Running total follows the same net rule as the individual counters.
  always_comb begin
    total_next = total_reg;
    uf_next    = uf_reg | wb_uf_evt;
    if (issue_acc && !wb_dec) begin
      total_next = total_reg + 1'b1;
    end else if (!issue_acc && wb_dec) begin
      total_next = total_reg - 1'b1;
    end
  end

  // State registers; reset discards every pending write and the error flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        cnt_reg[i] <= '0;
      end
      total_reg <= '0;
      uf_reg    <= 1'b0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        cnt_reg[i] <= cnt_next[i];
      end
      total_reg <= total_next;
      uf_reg    <= uf_next;
    end
  end

  assign sb.issue_ready   = issue_ready_w;
  assign sb.busy_vec      = busy;
  assign sb.total_pending = total_reg;
  assign sb.wb_underflow  = uf_reg;

`ifdef SB_WB_BYPASS_EN
  // Last outstanding write lands this cycle, so the register file forwards it.
  assign sb.rs_busy = busy[sb.rs_addr] &&
                      !(sb.wb_valid && (sb.wb_dest == sb.rs_addr) && (cnt_reg[sb.rs_addr] == CNT_W'(1)));
  assign sb.rt_busy = busy[sb.rt_addr] &&
                      !(sb.wb_valid && (sb.wb_dest == sb.rt_addr) && (cnt_reg[sb.rt_addr] == CNT_W'(1)));
`else
  assign sb.rs_busy = busy[sb.rs_addr];
  assign sb.rt_busy = busy[sb.rt_addr];
`endif
endmodule

// File: tb/tb_dest_reg_scoreboard.sv
// Self-checking bench for dest_reg_scoreboard: a per-register count model
// checked against the DUT every cycle, plus directed literal expectations.
module tb_dest_reg_scoreboard;
  localparam int ADDR_W = 5;
  localparam int NREG   = 32;
  localparam int CNT_W  = 2;
  localparam int MAXC   = 3;
`ifdef SB_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dest_reg_scoreboard_if #(.ADDR_W(ADDR_W), .NREG(NREG), .CNT_W(CNT_W)) sb_if ();

  dest_reg_scoreboard #(.ADDR_W(ADDR_W), .NREG(NREG), .CNT_W(CNT_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .sb   (sb_if.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  int model_cnt [NREG];
  bit model_uf   = 1'b0;
  bit model_live = 1'b0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic bit exp_ready();
    int d;
    d = int'(sb_if.issue_dest);
    return !(d != 0 && model_cnt[d] == MAXC && !(sb_if.wb_valid && sb_if.wb_dest == sb_if.issue_dest));
  endfunction

  function automatic bit exp_busy(input int a);
    bit b;
    b = (a != 0) && (model_cnt[a] != 0);
    if (BYP && sb_if.wb_valid && int'(sb_if.wb_dest) == a && model_cnt[a] == 1) b = 1'b0;
    return b;
  endfunction

  function automatic logic [NREG-1:0] exp_vec();
    logic [NREG-1:0] v;
    v = '0;
    for (int i = 1; i < NREG; i++) v[i] = (model_cnt[i] != 0);
    return v;
  endfunction

  function automatic int exp_total();
    int s;
    s = 0;
    for (int i = 0; i < NREG; i++) s += model_cnt[i];
    return s;
  endfunction

  // Model state update at each rising edge, one log line per transaction.
  always begin
    @(posedge clk);
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) model_cnt[i] = 0;
      model_uf   = 1'b0;
      model_live = 1'b1;
    end else begin
      int d;
      int w;
      d = int'(sb_if.issue_dest);
      w = int'(sb_if.wb_dest);
      if (sb_if.issue_valid && d != 0) begin
        if (exp_ready()) begin
          model_cnt[d] = model_cnt[d] + 1;
          $display("%0t issue accepted dest=%0d", $time, d);
        end else begin
          $display("%0t issue stalled dest=%0d", $time, d);
        end
      end
      if (sb_if.wb_valid && w != 0) begin
        if (model_cnt[w] == 0) begin
          model_uf = 1'b1;
          $display("%0t writeback dest=%0d with nothing outstanding", $time, w);
        end else begin
          model_cnt[w] = model_cnt[w] - 1;
          $display("%0t writeback dest=%0d", $time, w);
        end
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always begin
    @(negedge clk);
    #1;
    if (model_live) begin
      check("issue_ready",   sb_if.issue_ready,   exp_ready());
      check("rs_busy",       sb_if.rs_busy,       exp_busy(int'(sb_if.rs_addr)));
      check("rt_busy",       sb_if.rt_busy,       exp_busy(int'(sb_if.rt_addr)));
      check("busy_vec",      sb_if.busy_vec,      exp_vec());
      check("total_pending", sb_if.total_pending, exp_total());
      check("wb_underflow",  sb_if.wb_underflow,  model_uf);
    end
  end

  task automatic idle_inputs();
    sb_if.issue_valid = 1'b0;
    sb_if.wb_valid    = 1'b0;
  endtask

  initial begin
    sb_if.issue_valid = 1'b1;
    sb_if.issue_dest  = 5'd5;
    sb_if.wb_valid    = 1'b0;
    sb_if.wb_dest     = '0;
    sb_if.rs_addr     = '0;
    sb_if.rt_addr     = '0;

    // Reset held two edges while an issue is presented.
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    sb_if.issue_valid = 1'b0;
    #2;
    check("rst_busy_vec", sb_if.busy_vec, 32'd0);
    check("rst_total", sb_if.total_pending, 7'd0);
    check("rst_ready", sb_if.issue_ready, 1'b1);
    check("rst_uf", sb_if.wb_underflow, 1'b0);

    // Issue to r7, then retire it.
    @(negedge clk);
    sb_if.issue_valid = 1'b1; sb_if.issue_dest = 5'd7; sb_if.rs_addr = 5'd7;
    #2 check("r7_rs_busy_issue_cycle", sb_if.rs_busy, 1'b0);
    @(negedge clk);
    idle_inputs();
    #2;
    check("r7_busy_bit", sb_if.busy_vec[7], 1'b1);
    check("r7_rs_busy", sb_if.rs_busy, 1'b1);
    check("r7_total", sb_if.total_pending, 7'd1);
    repeat (2) @(negedge clk);
    sb_if.wb_valid = 1'b1; sb_if.wb_dest = 5'd7;
    #2 check("r7_total_before_wb", sb_if.total_pending, 7'd1);
    @(negedge clk);
    idle_inputs();
    #2;
    check("r7_busy_cleared", sb_if.busy_vec[7], 1'b0);
    check("r7_total_zero", sb_if.total_pending, 7'd0);

    // Saturation on r9, then a same-cycle issue+write-back at the limit.
    @(negedge clk);
    sb_if.issue_valid = 1'b1; sb_if.issue_dest = 5'd9;
    repeat (3) @(negedge clk);
    #2;
    check("r9_full_ready", sb_if.issue_ready, 1'b0);
    check("r9_full_total", sb_if.total_pending, 7'd3);
    @(negedge clk);
    sb_if.wb_valid = 1'b1; sb_if.wb_dest = 5'd9;
    #2 check("r9_ready_with_wb", sb_if.issue_ready, 1'b1);
    @(negedge clk);
    idle_inputs();
    #2;
    check("r9_total_after_swap", sb_if.total_pending, 7'd3);
    check("r9_still_full", sb_if.issue_ready, 1'b0);
    sb_if.wb_valid = 1'b1; sb_if.wb_dest = 5'd9;
    repeat (3) @(negedge clk);
    idle_inputs();
    #2 check("r9_drained", sb_if.total_pending, 7'd0);

    // Register zero never tracks anything.
    sb_if.issue_valid = 1'b1; sb_if.issue_dest = 5'd0;
    sb_if.wb_valid = 1'b1; sb_if.wb_dest = 5'd0;
    sb_if.rs_addr = 5'd0; sb_if.rt_addr = 5'd0;
    repeat (3) @(negedge clk);
    #2;
    check("r0_rs_busy", sb_if.rs_busy, 1'b0);
    check("r0_busy_vec", sb_if.busy_vec, 32'd0);
    check("r0_total", sb_if.total_pending, 7'd0);
    check("r0_uf", sb_if.wb_underflow, 1'b0);
    idle_inputs();

    // Same-cycle write-back of the single outstanding write to r3.
    @(negedge clk);
    sb_if.issue_valid = 1'b1; sb_if.issue_dest = 5'd3;
    @(negedge clk);
    idle_inputs();
    sb_if.wb_valid = 1'b1; sb_if.wb_dest = 5'd3; sb_if.rt_addr = 5'd3;
    #2;
    check("r3_rt_busy_wb_cycle", sb_if.rt_busy, BYP ? 1'b0 : 1'b1);
    check("r3_busy_bit_wb_cycle", sb_if.busy_vec[3], 1'b1);
    @(negedge clk);
    idle_inputs();
    #2 check("r3_rt_busy_after", sb_if.rt_busy, 1'b0);

    // Different registers in one cycle, then same register from zero.
    sb_if.issue_valid = 1'b1; sb_if.issue_dest = 5'd4;
    @(negedge clk);
    sb_if.issue_dest = 5'd6; sb_if.wb_valid = 1'b1; sb_if.wb_dest = 5'd4;
    @(negedge clk);
    idle_inputs();
    #2;
    check("mix_total", sb_if.total_pending, 7'd1);
    check("mix_busy_vec", sb_if.busy_vec, 32'h0000_0040);
    sb_if.issue_valid = 1'b1; sb_if.issue_dest = 5'd8; sb_if.wb_valid = 1'b1; sb_if.wb_dest = 5'd8;
    @(negedge clk);
    idle_inputs();
    #2;
    check("same_zero_total", sb_if.total_pending, 7'd1);
    check("same_zero_uf", sb_if.wb_underflow, 1'b0);
    sb_if.wb_valid = 1'b1; sb_if.wb_dest = 5'd6;
    @(negedge clk);
    idle_inputs();

    // Write-back to idle r12 sets the sticky error.
    sb_if.wb_valid = 1'b1; sb_if.wb_dest = 5'd12;
    @(negedge clk);
    idle_inputs();
    #2;
    check("uf_set", sb_if.wb_underflow, 1'b1);
    check("uf_r12_idle", sb_if.busy_vec[12], 1'b0);
    check("uf_total", sb_if.total_pending, 7'd0);
    repeat (3) @(negedge clk);
    #2 check("uf_sticky", sb_if.wb_underflow, 1'b1);

    // Reset in the middle of pending work.
    sb_if.issue_valid = 1'b1; sb_if.issue_dest = 5'd11;
    repeat (2) @(negedge clk);
    idle_inputs();
    #2 check("pre_reset_total", sb_if.total_pending, 7'd2);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #2;
    check("mid_rst_uf", sb_if.wb_underflow, 1'b0);
    check("mid_rst_total", sb_if.total_pending, 7'd0);
    check("mid_rst_busy_vec", sb_if.busy_vec, 32'd0);
    repeat (2) @(negedge clk);
    #2;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/dest_reg_scoreboard.md
Name: dest_reg_scoreboard

Overview:
- Consumer-side counterpart of the 5-bit destination-register select mux.
- Takes the selected destination register number at issue and decodes it into per-register pending-write state.
- Retires that state when the write-back stage reports the same register number.
- Sits between decode/issue and write-back of the 32-entry register-file pipeline. Gives issue logic per-source busy flags used to stall on RAW hazards.

Parameters:
- ADDR_W, 5, register-number width
- NREG, 32, number of architectural registers (2**ADDR_W)
- CNT_W, 2, width of the per-register outstanding-write counter; max outstanding = 2**CNT_W-1

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- issue_valid  input  1  instruction with a destination is issuing
- issue_dest  input  ADDR_W  destination register number (output of dest-select mux)
- issue_ready  output  1  issue accepted this cycle
- wb_valid  input  1  write-back of a register this cycle
- wb_dest  input  ADDR_W  register being written back
- rs_addr  input  ADDR_W  source register A to check
- rt_addr  input  ADDR_W  source register B to check
- rs_busy  output  1  source A has an outstanding write
- rt_busy  output  1  source B has an outstanding write
- busy_vec  output  NREG  bit i = register i has outstanding write(s)
- total_pending  output  ADDR_W+CNT_W  sum of all outstanding writes
- wb_underflow  output  1  sticky error: write-back with no matching issue

Behaviour:
- Reset: synchronous, rst_n low at a rising edge. Sampled only on the clock edge; mid-operation reset discards all pending state.
  - Clears every counter, total_pending and wb_underflow.
  - Hence busy_vec=0, rs_busy=0, rt_busy=0, issue_ready=1 the cycle after reset.
- State: cnt[i], CNT_W bits, one per register.
  - busy_vec[i] = (cnt[i]!=0).
  - Register 0 is hardwired zero: cnt[0] never increments; busy_vec[0], and rs_busy/rt_busy for address 0, are always 0.
- Issue handshake: issue_ready = !(cnt[issue_dest] == max && !(wb_valid && wb_dest==issue_dest)).
  - Combinational; independent of issue_valid.
  - Accepted when issue_valid && issue_ready: cnt[issue_dest] +1 at the next edge.
  - issue_dest==0: always ready; no state change.
  - Not accepted: no state change. Upstream holds issue_valid/issue_dest until ready.
- Write-back, wb_valid:
  - cnt[wb_dest] -1 at the next edge.
  - If cnt[wb_dest]==0 and no same-cycle accepted issue to wb_dest: counter stays 0 (no wrap) and wb_underflow sets, sticky until reset.
  - wb_dest==0: ignored, no error.
- Simultaneous accepted issue and wb to the same nonzero register: count unchanged, no underflow (even from 0).
- Simultaneous to different registers: both updates apply.
- Counter wrap: impossible by construction. Increment is blocked at max; decrement is clamped at 0.
- rs_busy / rt_busy:
  - Combinational lookup of busy_vec at rs_addr / rt_addr.
  - Zero latency relative to the registered state.
  - An issue accepted in cycle N makes its register busy from cycle N+1.
- total_pending: registered; updated with the same +1/-1/0 net rule in the same edge as the counters; reset 0.

Optional Feature:
- Macro SB_WB_BYPASS_EN.
- Defined: rs_busy/rt_busy are masked to 0 in the cycle a wb_valid with matching wb_dest occurs and cnt for that register is exactly 1. Covers same-cycle write-then-read through the register file. busy_vec is unaffected.
- Undefined: rs_busy/rt_busy reflect only registered cnt state; a consumer stalls one extra cycle.

Test Plan:
- Reset: hold rst_n=0 two cycles with issue_valid=1, issue_dest=5 → busy_vec=0, total_pending=0, issue_ready=1, wb_underflow=0 after release.
- Issue then write-back:
  - Issue dest=7 at cycle 1 → busy_vec[7]=1 and rs_busy=1 (rs_addr=7) from cycle 2.
  - wb_dest=7 at cycle 4 → busy_vec[7]=0 at cycle 5; total_pending goes 1→0.
- Saturation:
  - Three accepted issues to dest=9 → cnt=3, issue_ready=0 for dest=9.
  - Fourth issue held; assert wb_valid, wb_dest=9 in the same cycle → issue_ready=1, accepted, cnt stays 3.
- Register zero: issue dest=0 and wb dest=0 repeatedly, rs_addr=0 → rs_busy=0, busy_vec=0, total_pending=0, wb_underflow=0.
- Underflow: wb_valid with wb_dest=12 while idle → cnt[12] stays 0, wb_underflow=1 and remains 1 until rst_n=0.
- Bypass, dest=3 with cnt=1, wb_dest=3, rt_addr=3 → rt_busy=0 with SB_WB_BYPASS_EN defined; rt_busy=1 with it undefined.
